// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN  = 3'd2,
        ST_HI   = 3'd3,
        ST_LO   = 3'd4,
        ST_CSUM = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake from the host plus the instruction-memory write port.
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Frame parser that assembles 16-bit words from host bytes, writes them to
// instruction memory and holds the CPU until a frame passes its checksum.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SYNC  | dropping bytes until the 0xA5 sync byte
// LEN   | next byte is the word count N
// HI    | next byte is the high byte of a word
// LO    | next byte is the low byte; write issued the following cycle
// CSUM  | next byte is the 8-bit sum of all data bytes
// DONE  | frame accepted, CPU released
// ERR   | frame rejected (bad length or checksum), CPU held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              ADDR_W        = 16,
    parameter int              DEPTH         = 256,
    parameter int              BASE_ADDR     = 0,
    parameter bit              HOLD_AT_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [7:0]    word_count
);

    // N is an 8-bit field, so any DEPTH of 255 or more never rejects on length.
    localparam int         DEPTH_LIM = (DEPTH > 255) ? 255 : DEPTH;
    localparam logic [7:0] DEPTH_MAX = 8'(DEPTH_LIM);

    loader_state_t     state_q, state_d;
    logic              ready;
    logic              xfer;
    logic [7:0]        hi_q;
    logic [7:0]        csum_q;
    logic [7:0]        len_q;
    logic [7:0]        word_count_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              hold_q;
    logic              done_q;
    logic              error_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_SYNC, ST_LEN, ST_HI, ST_LO, ST_CSUM: ready = 1'b1;
            default: ready = 1'b0;
        endcase
        // A byte coinciding with start belongs to no frame.
        if (start) ready = 1'b0;
        xfer = bus.in_valid && ready;

        if (start) begin
            state_d = ST_SYNC;
        end else if (xfer) begin
            case (state_q)
                ST_SYNC: if (bus.in_data == LOADER_SYNC) state_d = ST_LEN;
                ST_LEN: begin
                    if (bus.in_data == 8'd0 || bus.in_data > DEPTH_MAX) state_d = ST_ERR;
                    else                                                 state_d = ST_HI;
                end
                ST_HI: state_d = ST_LO;
                ST_LO: begin
                    if (word_count_q + 8'd1 == len_q) state_d = ST_CSUM;
                    else                              state_d = ST_HI;
                end
                ST_CSUM: begin
                    if (bus.in_data == csum_q) state_d = ST_DONE;
                    else                       state_d = ST_ERR;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q         <= 8'd0;
            csum_q       <= 8'd0;
            len_q        <= 8'd0;
            word_count_q <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= ADDR_W'(BASE_ADDR);
            wdata_q      <= 16'd0;
            hold_q       <= HOLD_AT_RESET;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                hold_q  <= 1'b1;
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end else if (xfer) begin
                case (state_q)
                    ST_LEN: begin
                        if (state_d == ST_ERR) begin
                            error_q <= 1'b1;
                            hold_q  <= 1'b1;
                        end else begin
                            len_q        <= bus.in_data;
                            word_count_q <= 8'd0;
                            csum_q       <= 8'd0;
                        end
                    end
                    ST_HI: begin
                        hi_q   <= bus.in_data;
                        csum_q <= csum_q + bus.in_data;
                    end
                    ST_LO: begin
                        csum_q       <= csum_q + bus.in_data;
                        we_q         <= 1'b1;
                        wdata_q      <= {hi_q, bus.in_data};
                        addr_q       <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_count_q);
                        word_count_q <= word_count_q + 8'd1;
                    end
                    ST_CSUM: begin
                        if (state_d == ST_DONE) begin
                            done_q <= 1'b1;
                            hold_q <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                            hold_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_hold       = hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = word_count_q;
    assign busy           = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed frames against a byte-index model of the loader, checked every cycle.
module tb_imem_loader;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 8;
    localparam int BASE   = 'hFFFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       cpu_hold, busy, done, error;
    logic [7:0] word_count;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE), .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: frame position tracked as a byte index k after the sync byte.
    logic        m_live = 1'b0;
    logic        m_active, m_synced, m_we, m_hold, m_done, m_err;
    logic [15:0] m_addr, m_wdata;
    logic [7:0]  m_hi, m_sum, m_wc, b;
    int          m_k, m_n;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1'b1; m_active = 1'b0; m_synced = 1'b0; m_we = 1'b0;
            m_addr = 16'(BASE); m_wdata = 16'd0; m_hold = 1'b1;
            m_done = 1'b0; m_err = 1'b0; m_wc = 8'd0; m_k = 0; m_n = 0;
            m_sum = 8'd0; m_hi = 8'd0;
        end else if (m_live) begin
            m_we = 1'b0;
            if (start) begin
                m_active = 1'b1; m_synced = 1'b0;
                m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
            end else if (m_active && bus.in_valid) begin
                b = bus.in_data;
                if (!m_synced) begin
                    m_synced = (b == 8'hA5);
                    m_k = 0;
                end else if (m_k == 0) begin
                    if (b == 0 || int'(b) > DEPTH) begin
                        m_active = 1'b0; m_err = 1'b1; m_hold = 1'b1;
                    end else begin
                        m_n = int'(b); m_wc = 8'd0; m_sum = 8'd0; m_k = 1;
                    end
                end else if (m_k <= 2 * m_n) begin
                    m_sum = m_sum + b;
                    if (m_k % 2 == 1) m_hi = b;
                    else begin
                        m_we = 1'b1;
                        m_addr = 16'(BASE + m_k / 2 - 1);
                        m_wdata = {m_hi, b};
                        m_wc = 8'(m_k / 2);
                    end
                    m_k++;
                end else begin
                    m_active = 1'b0;
                    if (b == m_sum) begin m_done = 1'b1; m_hold = 1'b0; end
                    else begin m_err = 1'b1; m_hold = 1'b1; end
                end
            end
        end
    end

    logic [15:0] mem_act [int];

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready",   32'(bus.in_ready),   32'(m_active && !start));
            chk("imem_we",    32'(bus.imem_we),    32'(m_we));
            chk("imem_addr",  32'(bus.imem_addr),  32'(m_addr));
            chk("imem_wdata", 32'(bus.imem_wdata), 32'(m_wdata));
            chk("cpu_hold",   32'(cpu_hold),       32'(m_hold));
            chk("busy",       32'(busy),           32'(m_active));
            chk("done",       32'(done),           32'(m_done));
            chk("error",      32'(error),          32'(m_err));
            chk("word_count", 32'(word_count),     32'(m_wc));
        end
        if (bus.imem_we === 1'b1) mem_act[int'(bus.imem_addr)] = bus.imem_wdata;
    end

    function automatic logic [31:0] mem_rd(input int a);
        if (mem_act.exists(a)) return 32'(mem_act[a]);
        return 32'hDEAD_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL handshake_timeout: byte %h not accepted within 8 cycles", d);
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit toggle);
        foreach (bytes[i]) begin
            send(bytes[i]);
            if (toggle) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_start(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_good_image(input string tag);
        chk({tag, "_mem0"}, mem_rd('hFFFF), 32'h1234);
        chk({tag, "_mem1_wrap"}, mem_rd(0), 32'hABCD);
        chk({tag, "_nwrites"}, 32'(mem_act.num()), 32'd2);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_wc"}, 32'(word_count), 32'd2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_hold",  32'(cpu_hold),     32'd1);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we",    32'(bus.imem_we),  32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_error", 32'(error),        32'd0);

        // 0x12+0x34+0xAB+0xCD = 0x1BE -> checksum 0xBE
        mem_act.delete();
        pulse_start(1'b0, 8'h00);
        send_frame('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE}, 1'b0);
        check_good_image("s2");

        // byte offered together with start must be ignored
        mem_act.delete();
        pulse_start(1'b1, 8'hA5);
        send_frame('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h12, 8'h34, 8'h00}, 1'b0);
        chk("s3_mem0",    mem_rd('hFFFF),          32'h1234);
        chk("s3_nwrites", 32'(mem_act.num()),      32'd1);
        chk("s3_error",   32'(error),              32'd1);
        chk("s3_hold",    32'(cpu_hold),           32'd1);
        chk("s3_done",    32'(done),               32'd0);

        mem_act.delete();
        pulse_start(1'b0, 8'h00);
        send_frame('{8'hA5, 8'h00}, 1'b0);
        chk("s4a_error",   32'(error),         32'd1);
        chk("s4a_nwrites", 32'(mem_act.num()), 32'd0);
        pulse_start(1'b0, 8'h00);
        send_frame('{8'hA5, 8'(DEPTH + 1)}, 1'b0);
        chk("s4b_error",   32'(error),         32'd1);
        chk("s4b_nwrites", 32'(mem_act.num()), 32'd0);

        mem_act.delete();
        pulse_start(1'b0, 8'h00);
        send_frame('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE}, 1'b1);
        check_good_image("s5");

        mem_act.delete();
        pulse_start(1'b0, 8'h00);
        send(8'hA5); send(8'h02); send(8'h56); send(8'h78); send(8'h9A);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("s6_mem0",    mem_rd('hFFFF),     32'h5678);
        chk("s6_nwrites", 32'(mem_act.num()), 32'd1);
        chk("s6_hold",    32'(cpu_hold),      32'd1);
        chk("s6_busy",    32'(busy),          32'd0);
        chk("s6_ready",   32'(bus.in_ready),  32'd0);
        chk("s6_wc",      32'(word_count),    32'd0);
        chk("s6_addr",    32'(bus.imem_addr), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
